// File: rtl/gf_tab_pkg.sv
// Shared types and helpers for the GF(256) table arbiter and related schedulers.
package gf_tab_pkg;

  localparam int GF_W    = 8;
  localparam int MAX_REQ = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    BUSY  = 3'b010,
    DRAIN = 3'b100
  } gf_state_t;

  // One-hot winner: first set request at or after rr_ptr, wrapping modulo nreq.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [1:0]         rr_ptr,
                                                 input int                 nreq);
    logic [MAX_REQ-1:0] win;
    int                 pos;
    win = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      pos = (int'(rr_ptr) + k) % nreq;
      if (k < nreq && req[pos[1:0]]) begin
        win             = '0;
        win[pos[1:0]]   = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/gf_rr_picker.sv
// Combinational round-robin winner select (one-hot and encoded index).
module gf_rr_picker
  import gf_tab_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      rr_ptr,
  output logic [NREQ-1:0] winner,
  output logic [1:0]      winner_idx,
  output logic            any_req
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    pick               = rr_pick(req_ext, rr_ptr, NREQ);
    winner             = pick[NREQ-1:0];
    any_req            = |req;
    winner_idx         = 2'd0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (pick[k]) winner_idx = 2'(k);
    end
  end

endmodule

// File: rtl/gf_table_arbiter.sv
// Round-robin, burst-locked arbiter sharing the GF(256) pow/dec table ports between decoder stages.
// Optional burst timeout enabled by defining GF_BURST_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; grant the round-robin winner of pending requests
// BUSY  | owner holds all three table ports until it drops req
// DRAIN | ROM_LAT cycles letting the last in-flight reads return
module gf_table_arbiter
  import gf_tab_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int ROM_LAT   = 1,
  parameter int MAX_BURST = 500
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [GF_W*NREQ-1:0] req_pow1,
  input  logic [GF_W*NREQ-1:0] req_pow2,
  input  logic [GF_W*NREQ-1:0] req_dec1,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rd_valid,
  output logic [GF_W-1:0]      add_pow1,
  output logic [GF_W-1:0]      add_pow2,
  output logic [GF_W-1:0]      add_dec1,
  output logic                 burst_err
);

  if (NREQ < 2 || NREQ > 4 || ROM_LAT < 1 || ROM_LAT > 2 || MAX_BURST < 2 || MAX_BURST > 512) begin : g_param_chk
    $error("gf_table_arbiter: parameter out of range");
  end

  localparam logic [1:0] LAST_REQ   = 2'(NREQ - 1);
  localparam logic [1:0] DRAIN_INIT = 2'(ROM_LAT - 1);

  gf_state_t       state, state_nxt;
  logic [1:0]      owner, owner_nxt;
  logic [1:0]      rr_ptr, rr_ptr_nxt;
  logic [1:0]      drain_cnt, drain_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [NREQ-1:0] pick_onehot;
  logic [1:0]      pick_idx;
  logic            any_req;
  logic            release_now;

  logic [ROM_LAT-1:0][NREQ-1:0] vld_pipe;

  gf_rr_picker #(.NREQ(NREQ)) u_picker (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any_req    (any_req)
  );

`ifdef GF_BURST_TIMEOUT_EN
  localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST - 1);
  logic [8:0] bcnt, bcnt_nxt;
  logic       err_q, err_nxt;
  assign burst_err = err_q;
`else
  assign burst_err = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    rr_ptr_nxt  = rr_ptr;
    drain_nxt   = drain_cnt;
    gnt_nxt     = gnt;
    release_now = 1'b0;
`ifdef GF_BURST_TIMEOUT_EN
    bcnt_nxt    = bcnt;
    err_nxt     = err_q;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt = pick_idx;
          gnt_nxt   = pick_onehot;
          state_nxt = BUSY;
`ifdef GF_BURST_TIMEOUT_EN
          bcnt_nxt  = '0;
`endif
        end
      end
      BUSY: begin
        release_now = !req[owner];
`ifdef GF_BURST_TIMEOUT_EN
        if (bcnt == BURST_LIMIT) begin
          release_now = 1'b1;
          err_nxt     = 1'b1;
        end else begin
          bcnt_nxt    = bcnt + 9'd1;
        end
`endif
        if (release_now) begin
          gnt_nxt    = '0;
          rr_ptr_nxt = (owner == LAST_REQ) ? 2'd0 : owner + 2'd1;
          drain_nxt  = DRAIN_INIT;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == 2'd0) state_nxt = IDLE;
        else                   drain_nxt = drain_cnt - 2'd1;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 2'd0;
      rr_ptr    <= 2'd0;
      drain_cnt <= 2'd0;
      gnt       <= '0;
      vld_pipe  <= '0;
`ifdef GF_BURST_TIMEOUT_EN
      bcnt      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      drain_cnt <= drain_nxt;
      gnt       <= gnt_nxt;
      vld_pipe[0] <= gnt;
      for (int i = 1; i < ROM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
`ifdef GF_BURST_TIMEOUT_EN
      bcnt      <= bcnt_nxt;
      err_q     <= err_nxt;
`endif
    end
  end

  assign rd_valid = vld_pipe[ROM_LAT-1];

  // Table addresses are zero outside BUSY; decimal entry 0 is a harmless read.
  always_comb begin
    add_pow1 = '0;
    add_pow2 = '0;
    add_dec1 = '0;
    if (state == BUSY) begin
      add_pow1 = req_pow1[owner*GF_W +: GF_W];
      add_pow2 = req_pow2[owner*GF_W +: GF_W];
      add_dec1 = req_dec1[owner*GF_W +: GF_W];
    end
  end

endmodule

// File: tb/tb_gf_table_arbiter.sv
// Directed bench for gf_table_arbiter (NREQ=3, ROM_LAT=1, MAX_BURST=8); honours GF_BURST_TIMEOUT_EN.
module tb_gf_table_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] req_pow1 = '0;
  logic [23:0] req_pow2 = '0;
  logic [23:0] req_dec1 = '0;
  logic [2:0]  gnt;
  logic [2:0]  rd_valid;
  logic [7:0]  add_pow1;
  logic [7:0]  add_pow2;
  logic [7:0]  add_dec1;
  logic        burst_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gf_table_arbiter #(.NREQ(3), .ROM_LAT(1), .MAX_BURST(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_pow1  (req_pow1),
    .req_pow2  (req_pow2),
    .req_dec1  (req_dec1),
    .gnt       (gnt),
    .rd_valid  (rd_valid),
    .add_pow1  (add_pow1),
    .add_pow2  (add_pow2),
    .add_dec1  (add_dec1),
    .burst_err (burst_err)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    req   = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0; req_pow1 = '0; req_pow2 = '0; req_dec1 = '0;
    step(); step();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL reset_rd_valid got=%b exp=000", rd_valid); end
    checks++; if (add_pow1 !== 8'h00) begin errors++; $display("FAIL reset_add_pow1 got=%h exp=00", add_pow1); end
    checks++; if (add_pow2 !== 8'h00) begin errors++; $display("FAIL reset_add_pow2 got=%h exp=00", add_pow2); end
    checks++; if (add_dec1 !== 8'h00) begin errors++; $display("FAIL reset_add_dec1 got=%h exp=00", add_dec1); end
    checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL reset_burst_err got=%b exp=0", burst_err); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] e1, e2;
    req = 3'b001;
    step();
    for (int k = 0; k < 10; k++) begin
      e1 = 8'(k * 5 + 1);
      e2 = 8'(k + 100);
      req_pow1[7:0] = e1;
      req_pow2[7:0] = e2;
      #1;
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt k=%0d got=%b exp=001", k, gnt); end
      checks++; if (add_pow1 !== e1) begin errors++; $display("FAIL single_add_pow1 k=%0d got=%h exp=%h", k, add_pow1, e1); end
      checks++; if (add_pow2 !== e2) begin errors++; $display("FAIL single_add_pow2 k=%0d got=%h exp=%h", k, add_pow2, e2); end
      checks++; if (rd_valid !== ((k == 0) ? 3'b000 : 3'b001)) begin errors++; $display("FAIL single_rd_valid k=%0d got=%b", k, rd_valid); end
      if (k < 9) step();
    end
    req = 3'b000;
    step();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL single_release_gnt got=%b exp=000", gnt); end
    checks++; if (rd_valid !== 3'b001) begin errors++; $display("FAIL single_tail_rd_valid got=%b exp=001", rd_valid); end
    checks++; if (add_pow1 !== 8'h00) begin errors++; $display("FAIL single_drain_addr got=%h exp=00", add_pow1); end
    step();
    checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL single_rd_valid_clear got=%b exp=000", rd_valid); end
  endtask

  task automatic test_back_to_back();
    int         exp_order [4] = '{0, 1, 2, 0};
    logic [2:0] e;
    logic [7:0] ea;
    int         gap;
    pulse_reset();
    for (int i = 0; i < 3; i++) req_pow1[8*i +: 8] = 8'(16 * (i + 1));
    req = 3'b111;
    step();
    for (int b = 0; b < 4; b++) begin
      e = '0;
      e[exp_order[b]] = 1'b1;
      ea = 8'(16 * (exp_order[b] + 1));
      checks++; if (gnt !== e) begin errors++; $display("FAIL b2b_order b=%0d got=%b exp=%b", b, gnt, e); end
      checks++; if (add_pow1 !== ea) begin errors++; $display("FAIL b2b_addr b=%0d got=%h exp=%h", b, add_pow1, ea); end
      for (int c = 1; c < 4; c++) begin
        step();
        checks++; if (gnt !== e) begin errors++; $display("FAIL b2b_hold b=%0d c=%0d got=%b exp=%b", b, c, gnt, e); end
      end
      req[exp_order[b]] = 1'b0;
      step();
      req = 3'b111;
      gap = 1;
      step();
      while (gnt === 3'b000 && gap < 20) begin
        gap++;
        step();
      end
      checks++; if (gap != 2) begin errors++; $display("FAIL b2b_gap b=%0d got=%0d exp=2", b, gap); end
    end
    req = 3'b000;
  endtask

  task automatic test_no_preempt();
    pulse_reset();
    req = 3'b010;
    step();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL nopre_grant got=%b exp=010", gnt); end
    step(); step();
    req = 3'b110;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL nopre_hold c=%0d got=%b exp=010", c, gnt); end
    end
    req = 3'b100;
    step();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL nopre_gap1 got=%b exp=000", gnt); end
    step();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL nopre_gap2 got=%b exp=000", gnt); end
    step();
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL nopre_next got=%b exp=100", gnt); end
    req = 3'b000;
  endtask

  task automatic test_reset_mid_burst();
    pulse_reset();
    req_pow1[15:8] = 8'hA5;
    req = 3'b010;
    step();
    step();
    checks++; if (rd_valid !== 3'b010) begin errors++; $display("FAIL rstmid_inflight got=%b exp=010", rd_valid); end
    reset = 1'b1;
    step();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rstmid_gnt got=%b exp=000", gnt); end
    checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL rstmid_rd_valid got=%b exp=000", rd_valid); end
    checks++; if (add_pow1 !== 8'h00) begin errors++; $display("FAIL rstmid_addr got=%h exp=00", add_pow1); end
    reset = 1'b0;
    step();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL rstmid_regrant got=%b exp=010", gnt); end
  endtask

  task automatic test_addr_isolation();
    req_pow1[7:0] = 8'h02; req_pow2[7:0] = 8'h03; req_dec1[7:0] = 8'hFF;
    req_pow1[15:8] = 8'h11; req_pow2[15:8] = 8'h22; req_dec1[15:8] = 8'h33;
    #1;
    checks++; if (add_pow1 !== 8'h11) begin errors++; $display("FAIL iso_pow1 got=%h exp=11", add_pow1); end
    checks++; if (add_pow2 !== 8'h22) begin errors++; $display("FAIL iso_pow2 got=%h exp=22", add_pow2); end
    checks++; if (add_dec1 !== 8'h33) begin errors++; $display("FAIL iso_dec1 got=%h exp=33", add_dec1); end
    step();
    req_pow1[7:0] = 8'h7E; req_dec1[7:0] = 8'h01;
    req_pow1[15:8] = 8'h44; req_pow2[15:8] = 8'h55; req_dec1[15:8] = 8'h66;
    #1;
    checks++; if (add_pow1 !== 8'h44) begin errors++; $display("FAIL iso2_pow1 got=%h exp=44", add_pow1); end
    checks++; if (add_pow2 !== 8'h55) begin errors++; $display("FAIL iso2_pow2 got=%h exp=55", add_pow2); end
    checks++; if (add_dec1 !== 8'h66) begin errors++; $display("FAIL iso2_dec1 got=%h exp=66", add_dec1); end
    req = 3'b000;
    step();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL iso_release got=%b exp=000", gnt); end
    checks++; if (add_dec1 !== 8'h00) begin errors++; $display("FAIL iso_idle_dec1 got=%h exp=00", add_dec1); end
  endtask

  task automatic test_burst_timeout();
    int hi;
    pulse_reset();
    req = 3'b001;
    step();
    hi = 0;
    while (gnt === 3'b001 && hi < 40) begin
      hi++;
      step();
    end
`ifdef GF_BURST_TIMEOUT_EN
    checks++; if (hi != 8) begin errors++; $display("FAIL tmo_len got=%0d exp=8", hi); end
    checks++; if (burst_err !== 1'b1) begin errors++; $display("FAIL tmo_err got=%b exp=1", burst_err); end
    step(); step();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL tmo_regrant got=%b exp=001", gnt); end
    checks++; if (burst_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%b exp=1", burst_err); end
`else
    checks++; if (hi != 40) begin errors++; $display("FAIL notmo_len got=%0d exp=40", hi); end
    checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL notmo_err got=%b exp=0", burst_err); end
`endif
    req = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_no_preempt();
    test_reset_mid_burst();
    test_addr_isolation();
    test_burst_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
